sn76489_bus_if: RTL and testbench
=================================

Name: sn76489_bus_if

Overview:
- Upstream stage of the SN76489-compatible sound core.
- Accepts CPU byte writes on the nWE/nCE/D bus and applies the SN76489 latch/data byte protocol.
- Holds the architectural register file (4 volumes, 3 tone dividers, noise control) that the tone/noise generators and mixer consume.
- Drives READY to stall the CPU while a write is being absorbed.

Parameters:
- BUSY_CYCLES, 32, CLK cycles READY is held low after each accepted write (range 1..255).
- SYNC_STAGES, 2, flip-flop depth of the synchroniser on nWE and nCE (min 2).

Ports:
- CLK  input  1  core clock
- nRST  input  1  reset, synchronous, active-low
- nWE  input  1  write enable from CPU, active-low, asynchronous to CLK
- nCE  input  1  chip enable from CPU, active-low, asynchronous to CLK
- D  input  8  write data; stable for the whole strobe
- READY  output  1  high = can accept a write; low = busy
- vol0..vol3  output  4 each  attenuation per channel (0 = loudest, F = off); vol3 = noise channel
- tone0..tone2  output  10 each  tone divider per channel
- noise  output  3  noise control: [2] = white/periodic, [1:0] = shift rate
- noise_rst  output  1  one-cycle pulse when the noise register is written (LFSR reload)

Behaviour:
- Write strobe:
  - wr_n = nWE | nCE, passed through SYNC_STAGES flops.
  - A write is detected on the synced falling edge (previous 1, current 0) in cycle N.
  - D is captured into a holding register in cycle N. D itself is not synchronised.
- Register update and READY timing:
  - Register update and any noise_rst pulse are visible at cycle N+1.
  - READY goes low at N+1.
- FSM:
  - IDLE: READY=1. A detected edge moves to BUSY and loads the counter with BUSY_CYCLES-1.
  - BUSY: READY=0. Counter decrements each cycle. At 0, go to HOLD.
  - HOLD: READY=1. Stay until synced wr_n is high, then go to IDLE.
- READY low time: exactly BUSY_CYCLES cycles.
- Latch byte (D[7]=1):
  - latch_ch <= D[6:5]; latch_vol <= D[4].
  - latch_vol=1: vol[ch] <= D[3:0].
  - latch_vol=0, ch<3: tone[ch][3:0] <= D[3:0]; tone[ch][9:4] unchanged.
  - latch_vol=0, ch=3: noise <= D[2:0], noise_rst pulses; D[3] ignored.
- Data byte (D[7]=0), applied to the currently latched target:
  - tone ch<3: tone[ch][9:4] <= D[5:0]; [3:0] unchanged.
  - volume: vol[ch] <= D[3:0].
  - noise: noise <= D[2:0], noise_rst pulses.
  - D[6] ignored.
  - The latch is not changed by a data byte.
- Dropped writes:
  - Edge detected while in BUSY or HOLD: the write is dropped. No register change, no counter restart.
  - A falling edge cannot occur in HOLD without a prior release; any such edge is also dropped.
- Reset (nRST low at a CLK edge, including mid-BUSY):
  - State=IDLE, READY=1.
  - vol0..vol3=4'hF, tone0..tone2=0, noise=0, noise_rst=0.
  - latch_ch=0, latch_vol=0.
  - Synchroniser flops all 1.
  - If the strobe is still low after reset releases, it is not a falling edge, so no write occurs.
- Boundary values:
  - Tone value 0 is stored as-is; interpretation belongs to the generator.
  - Writing the same value still pulses noise_rst for noise writes.
  - Volume and tone writes produce no pulse.
- noise_rst: exactly one cycle wide, high only at N+1.

Test Plan:
- Reset, then idle 10 cycles -> READY=1, all vol=F, tone=0, noise=0, noise_rst=0.
- Write 0x8E then 0x0F -> tone0=0x0FE. READY low for exactly 32 cycles after each write, high after release.
- Write 0x9A -> vol0=A. Then data byte 0x03 -> vol0=3. tone0 unchanged.
- Write 0xE5 -> noise=5 with a 1-cycle noise_rst. Then 0x06 -> noise=6, second pulse. 0xF0 -> vol3=0, no pulse.
- Second strobe edge issued 10 cycles into BUSY with D=0xC1 -> ignored: tone2 unchanged, READY still rises at cycle 32.
- nRST asserted mid-BUSY after 0xA7 -> READY=1 next cycle, tone1=0, vol=F. A strobe held low across reset release causes no write.

Source files
------------

// File: rtl/sn76489_bus_if.sv
// rtl/sn76489_bus_if.sv - CPU write port and register file of the SN76489-compatible sound core
//
// Absorbs CPU byte writes on the nWE/nCE/D bus, applies the SN76489 latch/data
// byte protocol and holds the register file consumed by the tone/noise
// generators and the mixer. READY drops for BUSY_CYCLES clocks per accepted write.
//
// Ports:
//   CLK, nRST        core clock, synchronous active-low reset
//   nWE, nCE         CPU write strobe and chip enable (active-low, asynchronous)
//   D[7:0]           write data, stable for the whole strobe
//   READY            1 = can accept a write, 0 = busy
//   vol0..vol3       4-bit attenuation per channel (vol3 = noise channel)
//   tone0..tone2     10-bit tone dividers
//   noise[2:0]       noise control ([2] white/periodic, [1:0] shift rate)
//   noise_rst        one-cycle pulse on every noise register write

module sn76489_bus_if #(
  parameter int BUSY_CYCLES = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       nWE,
  input  logic       nCE,
  input  logic [7:0] D,
  output logic       READY,
  output logic [3:0] vol0,
  output logic [3:0] vol1,
  output logic [3:0] vol2,
  output logic [3:0] vol3,
  output logic [9:0] tone0,
  output logic [9:0] tone1,
  output logic [9:0] tone2,
  output logic [2:0] noise,
  output logic       noise_rst
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [7:0] CNT_LOAD = 8'(BUSY_CYCLES - 1);

  logic [SYNC_STAGES-1:0] wr_sync;
  logic [SYNC_STAGES-1:0] flush;
  logic                   wr_s;
  logic                   wr_prev;
  logic                   armed;
  logic                   wr_fall;
  logic                   accept;

  logic [1:0]             state;
  logic [7:0]             cnt;

  logic [3:0]             vol [4];
  logic [9:0]             tone0_q, tone1_q, tone2_q;
  logic [2:0]             noise_q;
  logic [1:0]             latch_ch;
  logic                   latch_vol;

  logic [1:0]             wr_ch;
  logic                   wr_vol;
  logic [9:0]             tone_cur;
  logic [9:0]             tone_new;

  assign wr_s = wr_sync[SYNC_STAGES-1];

  // Synchroniser on the combined strobe; flops reset to the idle (high) level.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wr_sync <= '1;
      flush   <= '0;
      wr_prev <= 1'b1;
      armed   <= 1'b0;
    end else begin
      wr_sync <= {wr_sync[SYNC_STAGES-2:0], nWE | nCE};
      flush   <= {flush[SYNC_STAGES-2:0], 1'b1};
      wr_prev <= wr_s;
      // The reset value of the synchroniser looks like a released strobe, so a
      // strobe held low across reset would otherwise show up as a falling
      // edge. Edges only count once a genuine post-reset high has been seen.
      armed   <= armed | (flush[SYNC_STAGES-1] & wr_s);
    end
  end

  assign wr_fall = armed & wr_prev & ~wr_s;
  assign accept  = wr_fall && (state == ST_IDLE);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state <= ST_BUSY;
            cnt   <= CNT_LOAD;
          end
        end
        ST_BUSY: begin
          if (cnt == 8'd0) state <= ST_HOLD;
          else             cnt   <= cnt - 8'd1;
        end
        ST_HOLD: begin
          if (wr_s) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign READY = (state != ST_BUSY);

  // Target of this byte: a latch byte names its own target, a data byte reuses the latch.
  always_comb begin
    wr_ch    = D[7] ? D[6:5] : latch_ch;
    wr_vol   = D[7] ? D[4]   : latch_vol;
    tone_cur = '0;
    case (wr_ch)
      2'd0:    tone_cur = tone0_q;
      2'd1:    tone_cur = tone1_q;
      2'd2:    tone_cur = tone2_q;
      default: tone_cur = '0;
    endcase
    tone_new = D[7] ? {tone_cur[9:4], D[3:0]} : {D[5:0], tone_cur[3:0]};
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      vol       <= '{default: 4'hF};
      tone0_q   <= '0;
      tone1_q   <= '0;
      tone2_q   <= '0;
      noise_q   <= '0;
      noise_rst <= 1'b0;
      latch_ch  <= '0;
      latch_vol <= 1'b0;
    end else begin
      noise_rst <= 1'b0;
      if (accept) begin
        if (D[7]) begin
          latch_ch  <= D[6:5];
          latch_vol <= D[4];
        end
        if (wr_vol) begin
          vol[wr_ch] <= D[3:0];
        end else begin
          case (wr_ch)
            2'd0: tone0_q <= tone_new;
            2'd1: tone1_q <= tone_new;
            2'd2: tone2_q <= tone_new;
            default: begin
              noise_q   <= D[2:0];
              noise_rst <= 1'b1;
            end
          endcase
        end
      end
    end
  end

  assign vol0  = vol[0];
  assign vol1  = vol[1];
  assign vol2  = vol[2];
  assign vol3  = vol[3];
  assign tone0 = tone0_q;
  assign tone1 = tone1_q;
  assign tone2 = tone2_q;
  assign noise = noise_q;

endmodule

// File: tb/tb_sn76489_bus_if.sv
// tb/tb_sn76489_bus_if.sv - self-checking bench for sn76489_bus_if
//
// Table of byte writes with the expected register file after each one, plus
// hand-written sequences for a dropped write during BUSY and reset mid-BUSY.

module tb_sn76489_bus_if;

  localparam int BUSY = 32;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       nWE = 1'b1;
  logic       nCE = 1'b1;
  logic [7:0] D = 8'h00;
  logic       READY;
  logic [3:0] vol0, vol1, vol2, vol3;
  logic [9:0] tone0, tone1, tone2;
  logic [2:0] noise;
  logic       noise_rst;

  int total = 0;
  int passed = 0;

  always #5 CLK = ~CLK;

  sn76489_bus_if #(.BUSY_CYCLES(BUSY), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .nRST(nRST), .nWE(nWE), .nCE(nCE), .D(D), .READY(READY),
    .vol0(vol0), .vol1(vol1), .vol2(vol2), .vol3(vol3),
    .tone0(tone0), .tone1(tone1), .tone2(tone2),
    .noise(noise), .noise_rst(noise_rst)
  );

  typedef struct {
    logic [7:0] d;
    bit         via_ce;
    bit         pulse;
    logic [3:0] v0, v1, v2, v3;
    logic [9:0] t0, t1, t2;
    logic [2:0] nz;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [63:0] regs();
    return {15'd0, vol0, vol1, vol2, vol3, tone0, tone1, tone2, noise};
  endfunction

  function automatic logic [63:0] mk(input logic [3:0] v0, v1, v2, v3,
                                     input logic [9:0] t0, t1, t2, input logic [2:0] nz);
    return {15'd0, v0, v1, v2, v3, t0, t1, t2, nz};
  endfunction

  // Assert the strobe; the second signal goes low one cycle after the first.
  task automatic strobe_low(input logic [7:0] d, input bit via_ce);
    @(negedge CLK);
    D = d;
    if (via_ce) nWE = 1'b0; else nCE = 1'b0;
    @(negedge CLK);
    if (via_ce) nCE = 1'b0; else nWE = 1'b0;
  endtask

  task automatic strobe_release();
    nWE = 1'b1;
    nCE = 1'b1;
  endtask

  // Advance negedge by negedge until READY is low; sample stays on the first low cycle.
  task automatic wait_low(input string name, inout int pulses);
    int n = 0;
    while (READY && n < 20) begin
      pulses += int'(noise_rst);
      n++;
      @(negedge CLK);
    end
    if (READY) chk({name, " ready_timeout"}, 64'd1, 64'd0);
  endtask

  task automatic count_low(inout int lowcnt, inout int pulses, input int maxn);
    int k = 0;
    while (!READY && k < maxn) begin
      lowcnt++;
      pulses += int'(noise_rst);
      k++;
      @(negedge CLK);
    end
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) @(negedge CLK);
  endtask

  task automatic do_write(input string name, input logic [7:0] d, input bit via_ce, input bit exp_pulse);
    int pulses = 0;
    int lowcnt = 0;
    strobe_low(d, via_ce);
    wait_low(name, pulses);
    chk({name, " pulse_at_n1"}, 64'(noise_rst), 64'(exp_pulse));
    count_low(lowcnt, pulses, 100);
    chk({name, " ready_low_cycles"}, 64'(lowcnt), 64'(BUSY));
    chk({name, " pulse_count"}, 64'(pulses), 64'(exp_pulse));
    strobe_release();
    settle(6);
  endtask

  initial begin
    int pulses;
    int lowcnt;
    int highs;

    vecs[0]  = '{8'h8E, 1'b0, 1'b0, 4'hF, 4'hF, 4'hF, 4'hF, 10'h00E, 10'h000, 10'h000, 3'd0};
    vecs[1]  = '{8'h0F, 1'b1, 1'b0, 4'hF, 4'hF, 4'hF, 4'hF, 10'h0FE, 10'h000, 10'h000, 3'd0};
    vecs[2]  = '{8'h9A, 1'b0, 1'b0, 4'hA, 4'hF, 4'hF, 4'hF, 10'h0FE, 10'h000, 10'h000, 3'd0};
    vecs[3]  = '{8'h03, 1'b0, 1'b0, 4'h3, 4'hF, 4'hF, 4'hF, 10'h0FE, 10'h000, 10'h000, 3'd0};
    vecs[4]  = '{8'hE5, 1'b0, 1'b1, 4'h3, 4'hF, 4'hF, 4'hF, 10'h0FE, 10'h000, 10'h000, 3'd5};
    vecs[5]  = '{8'h06, 1'b1, 1'b1, 4'h3, 4'hF, 4'hF, 4'hF, 10'h0FE, 10'h000, 10'h000, 3'd6};
    vecs[6]  = '{8'hF0, 1'b0, 1'b0, 4'h3, 4'hF, 4'hF, 4'h0, 10'h0FE, 10'h000, 10'h000, 3'd6};
    vecs[7]  = '{8'hE6, 1'b0, 1'b1, 4'h3, 4'hF, 4'hF, 4'h0, 10'h0FE, 10'h000, 10'h000, 3'd6};
    vecs[8]  = '{8'hAC, 1'b0, 1'b0, 4'h3, 4'hF, 4'hF, 4'h0, 10'h0FE, 10'h00C, 10'h000, 3'd6};
    vecs[9]  = '{8'h7F, 1'b0, 1'b0, 4'h3, 4'hF, 4'hF, 4'h0, 10'h0FE, 10'h3FC, 10'h000, 3'd6};
    vecs[10] = '{8'hC5, 1'b0, 1'b0, 4'h3, 4'hF, 4'hF, 4'h0, 10'h0FE, 10'h3FC, 10'h005, 3'd6};
    vecs[11] = '{8'h40, 1'b0, 1'b0, 4'h3, 4'hF, 4'hF, 4'h0, 10'h0FE, 10'h3FC, 10'h005, 3'd6};
    vecs[12] = '{8'hC0, 1'b1, 1'b0, 4'h3, 4'hF, 4'hF, 4'h0, 10'h0FE, 10'h3FC, 10'h000, 3'd6};
    vecs[13] = '{8'hDB, 1'b0, 1'b0, 4'h3, 4'hF, 4'hB, 4'h0, 10'h0FE, 10'h3FC, 10'h000, 3'd6};
    vecs[14] = '{8'hE8, 1'b0, 1'b1, 4'h3, 4'hF, 4'hB, 4'h0, 10'h0FE, 10'h3FC, 10'h000, 3'd0};

    settle(3);
    nRST = 1'b1;
    settle(10);
    chk("reset READY", 64'(READY), 64'd1);
    chk("reset regs", regs(), mk(4'hF, 4'hF, 4'hF, 4'hF, 10'h0, 10'h0, 10'h0, 3'd0));
    chk("reset noise_rst", 64'(noise_rst), 64'd0);

    foreach (vecs[i]) begin
      do_write($sformatf("vec%0d", i), vecs[i].d, vecs[i].via_ce, vecs[i].pulse);
      chk($sformatf("vec%0d regs", i), regs(),
          mk(vecs[i].v0, vecs[i].v1, vecs[i].v2, vecs[i].v3,
             vecs[i].t0, vecs[i].t1, vecs[i].t2, vecs[i].nz));
    end

    // Second strobe edge during BUSY is dropped and does not restart the count.
    pulses = 0;
    lowcnt = 0;
    strobe_low(8'hB4, 1'b0);
    wait_low("drop", pulses);
    count_low(lowcnt, pulses, 10);
    nWE = 1'b1;
    D = 8'hC1;
    count_low(lowcnt, pulses, 4);
    nWE = 1'b0;
    count_low(lowcnt, pulses, 100);
    chk("drop ready_low_cycles", 64'(lowcnt), 64'(BUSY));
    // Strobe still low in HOLD: READY stays high, nothing is written.
    highs = 0;
    for (int i = 0; i < 5; i++) begin
      highs += int'(READY);
      @(negedge CLK);
    end
    chk("hold ready_high", 64'(highs), 64'd5);
    strobe_release();
    settle(6);
    chk("drop regs", regs(), mk(4'h3, 4'h4, 4'hB, 4'h0, 10'h0FE, 10'h3FC, 10'h000, 3'd0));
    // Latch must still point at vol1 after the dropped 0xC1.
    do_write("latch_kept", 8'h05, 1'b0, 1'b0);
    chk("latch_kept regs", regs(), mk(4'h3, 4'h5, 4'hB, 4'h0, 10'h0FE, 10'h3FC, 10'h000, 3'd0));

    // Reset mid-BUSY with the strobe held low across reset release.
    pulses = 0;
    lowcnt = 0;
    strobe_low(8'hA7, 1'b0);
    wait_low("rst", pulses);
    chk("rst tone1_before", 64'(tone1), 64'h3F7);
    count_low(lowcnt, pulses, 5);
    nRST = 1'b0;
    @(negedge CLK);
    chk("rst READY", 64'(READY), 64'd1);
    chk("rst regs", regs(), mk(4'hF, 4'hF, 4'hF, 4'hF, 10'h0, 10'h0, 10'h0, 3'd0));
    nRST = 1'b1;
    lowcnt = 0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      lowcnt += int'(!READY);
      pulses += int'(noise_rst);
      @(negedge CLK);
    end
    chk("rst held_strobe no_busy", 64'(lowcnt), 64'd0);
    chk("rst held_strobe regs", regs(), mk(4'hF, 4'hF, 4'hF, 4'hF, 10'h0, 10'h0, 10'h0, 3'd0));
    strobe_release();
    settle(6);
    // Latch reset to channel 0 tone: a bare data byte lands in tone0[9:4].
    do_write("post_rst_data", 8'h0A, 1'b0, 1'b0);
    chk("post_rst_data regs", regs(), mk(4'hF, 4'hF, 4'hF, 4'hF, 10'h0A0, 10'h0, 10'h0, 3'd0));
    do_write("post_rst_vol", 8'h91, 1'b1, 1'b0);
    chk("post_rst_vol regs", regs(), mk(4'h1, 4'hF, 4'hF, 4'hF, 10'h0A0, 10'h0, 10'h0, 3'd0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
